// File: rtl/led_arbiter.sv
// led_arbiter: shares the board LEDs among N_REQ requesters. A round-robin
// arbiter picks one requester, a phase sequencer plays its flash pattern,
// and an idle heartbeat runs on blink when nobody is being served.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nobody granted; heartbeat runs; pick next requester from ptr
// LOAD   | winner granted; latch its pattern and repeat count
// ON     | lit phase of the pattern (led[0] high)
// OFF    | dark phase of the pattern
// DONE   | one-cycle done pulse to the winner, advance ptr
module led_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TICK_DIV  = 50000,
  parameter int SLOW_HALF = 250,
  parameter int FAST_HALF = 62
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   pattern,
  input  logic [4*N_REQ-1:0]   flashes,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic [1:0]           led,
  output logic                 blink
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PS_W  = $clog2(TICK_DIV + 1);
  localparam int PH_W  = $clog2(2 * SLOW_HALF + 1);
  localparam int BL_W  = $clog2(SLOW_HALF + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ON, S_OFF, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [1:0]       pat_q, pat_d;
  logic [3:0]       rem_q, rem_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PS_W-1:0]  presc_q;
  logic [BL_W-1:0]  blink_cnt_q;
  logic             tick;

  logic [IDX_W-1:0] pick_lo, pick_hi, pick, next_ptr;
  logic             any_lo, any_hi;
  logic [PH_W-1:0]  on_len, off_len, cur_len;
  logic             phase_last, aborting;
  logic [3:0]       fl_sel;

  // free-running tick prescaler, pulses tick at the wrap
  always_ff @(posedge clk50) begin
    if (rst) begin
      presc_q <= '0;
    end else if (presc_q == PS_W'(TICK_DIV - 1)) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PS_W'(1);
    end
  end

  assign tick = (presc_q == PS_W'(TICK_DIV - 1));

  // round-robin pick: lowest set bit at or above ptr, else lowest set bit overall
  always_comb begin
    pick_lo = '0;
    pick_hi = '0;
    any_lo  = 1'b0;
    any_hi  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_lo = IDX_W'(i);
        any_lo  = 1'b1;
      end
      if (req[i] && (i >= int'(ptr_q))) begin
        pick_hi = IDX_W'(i);
        any_hi  = 1'b1;
      end
    end
    pick = any_hi ? pick_hi : pick_lo;
  end

  // ON/OFF phase lengths in ticks for the latched pattern code
  always_comb begin
    case (pat_q)
      2'b00:   begin on_len = PH_W'(2 * SLOW_HALF); off_len = '0;               end
      2'b01:   begin on_len = PH_W'(SLOW_HALF);     off_len = PH_W'(SLOW_HALF); end
      2'b10:   begin on_len = PH_W'(FAST_HALF);     off_len = PH_W'(FAST_HALF); end
      default: begin on_len = PH_W'(FAST_HALF);     off_len = PH_W'(SLOW_HALF); end
    endcase
  end

  assign cur_len    = (state_q == S_OFF) ? off_len : on_len;
  assign phase_last = (phase_q == cur_len - PH_W'(1));
  assign next_ptr   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
  assign aborting   = ((state_q == S_LOAD) || (state_q == S_ON) || (state_q == S_OFF))
                      && !req[win_q];
  assign fl_sel     = flashes[{win_q, 2'b00} +: 4];

  // next-state and datapath updates for the arbiter/sequencer
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    if (aborting) begin
      state_d = S_IDLE;
      ptr_d   = next_ptr;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_lo) begin
            win_d   = pick;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          pat_d   = pattern[{win_q, 1'b0} +: 2];
          rem_d   = (fl_sel == 4'd0) ? 4'd1 : fl_sel;
          phase_d = '0;
          state_d = S_ON;
        end
        S_ON, S_OFF: begin
          if (tick) begin
            if (phase_last) begin
              phase_d = '0;
              if ((state_q == S_ON) && (off_len != '0)) begin
                state_d = S_OFF;
              end else begin
                rem_d   = rem_q - 4'd1;
                state_d = (rem_q == 4'd1) ? S_DONE : S_ON;
              end
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        S_DONE: begin
          ptr_d   = next_ptr;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
    end
  end

  // idle heartbeat; held cleared whenever a requester is being served
  always_ff @(posedge clk50) begin
    if (rst || (state_q != S_IDLE)) begin
      blink       <= 1'b0;
      blink_cnt_q <= '0;
    end else if (tick) begin
      if (blink_cnt_q == BL_W'(SLOW_HALF - 1)) begin
        blink_cnt_q <= '0;
        blink       <= ~blink;
      end else begin
        blink_cnt_q <= blink_cnt_q + BL_W'(1);
      end
    end
  end

  // grant/done/led decode from the current state
  always_comb begin
    grant = '0;
    done  = '0;
    if (state_q != S_IDLE) grant[win_q] = 1'b1;
    if (state_q == S_DONE) done[win_q]  = 1'b1;
    busy = (state_q != S_IDLE);
    led  = {busy, (state_q == S_ON)};
  end

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed scenarios for led_arbiter with small tick parameters
// (TICK_DIV=4, SLOW_HALF=4, FAST_HALF=2), so a 4-tick phase is 13..16 cycles.
module tb_led_arbiter;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  pattern = '0;
  logic [15:0] flashes = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  led;
  logic        blink;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk50 = ~clk50;

  led_arbiter #(
    .N_REQ(4), .TICK_DIV(4), .SLOW_HALF(4), .FAST_HALF(2)
  ) dut (
    .clk50(clk50), .rst(rst), .req(req), .pattern(pattern), .flashes(flashes),
    .grant(grant), .done(done), .busy(busy), .led(led), .blink(blink)
  );

  // cycles for which led[0] stays at lvl with no done pulse, from the current cycle
  task automatic seg_len(input logic lvl, output int n);
    n = 0;
    while (led[0] === lvl && done === 4'b0000 && n < 200) begin
      n++;
      @(negedge clk50);
    end
  endtask

  // advance until a done pulse is visible or the budget runs out
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done === 4'b0000 && n < budget) begin
      n++;
      @(negedge clk50);
    end
  endtask

  task automatic test_reset;
    int c;
    int d;
    rst = 1'b1;
    req = '0;
    @(negedge clk50);
    @(negedge clk50);
    rst = 1'b0;
    n_total++;
    if ({grant, done, busy, led, blink} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {grant, done, busy, led, blink});
    else n_pass++;
    c = 0;
    while (blink !== 1'b1 && c < 40) begin
      @(negedge clk50);
      c++;
    end
    n_total++;
    if (c < 13 || c > 16) $display("FAIL blink_first: got %0d cycles want 13..16", c);
    else n_pass++;
    d = 0;
    while (blink !== 1'b0 && d < 40) begin
      @(negedge clk50);
      d++;
    end
    n_total++;
    if (d != 16) $display("FAIL blink_period: got %0d cycles want 16", d);
    else n_pass++;
  endtask

  task automatic test_slow;
    int n;
    pattern[1:0] = 2'b01;
    flashes[3:0] = 4'd2;
    req = 4'b0001;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0001 || led !== 2'b10)
      $display("FAIL slow_load: got grant=%b led=%b want 0001/10", grant, led);
    else n_pass++;
    @(negedge clk50);
    n_total++;
    if (led !== 2'b11 || blink !== 1'b0)
      $display("FAIL slow_on_entry: got led=%b blink=%b want 11/0", led, blink);
    else n_pass++;
    seg_len(1'b1, n);
    n_total++;
    if (n < 13 || n > 16) $display("FAIL slow_on1: got %0d want 13..16", n); else n_pass++;
    seg_len(1'b0, n);
    n_total++;
    if (n < 13 || n > 16) $display("FAIL slow_off1: got %0d want 13..16", n); else n_pass++;
    seg_len(1'b1, n);
    n_total++;
    if (n < 13 || n > 16) $display("FAIL slow_on2: got %0d want 13..16", n); else n_pass++;
    seg_len(1'b0, n);
    n_total++;
    if (n < 13 || n > 16) $display("FAIL slow_off2: got %0d want 13..16", n); else n_pass++;
    n_total++;
    if (done !== 4'b0001 || grant !== 4'b0001)
      $display("FAIL slow_done: got done=%b grant=%b want 0001/0001", done, grant);
    else n_pass++;
    req = 4'b0000;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0)
      $display("FAIL slow_release: got grant=%b done=%b busy=%b want 0000/0000/0", grant, done, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    pattern = 8'b10_10_10_10;
    flashes = 16'h1111;
    rst = 1'b1;
    @(negedge clk50);
    rst = 1'b0;
    req = 4'b0101;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0001) $display("FAIL rr_first: got %b want 0001", grant); else n_pass++;
    wait_done(100);
    n_total++;
    if (done !== 4'b0001) $display("FAIL rr_done0: got %b want 0001", done); else n_pass++;
    req = 4'b0100;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0000) $display("FAIL rr_gap: got %b want 0000", grant); else n_pass++;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0100) $display("FAIL rr_second: got %b want 0100", grant); else n_pass++;
    wait_done(100);
    n_total++;
    if (done !== 4'b0100) $display("FAIL rr_done2: got %b want 0100", done); else n_pass++;
    req = 4'b0000;
    @(negedge clk50);
    req = 4'b1001;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b1000) $display("FAIL rr_wrap3: got %b want 1000", grant); else n_pass++;
    wait_done(100);
    n_total++;
    if (done !== 4'b1000) $display("FAIL rr_done3: got %b want 1000", done); else n_pass++;
    req = 4'b0001;
    @(negedge clk50);
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0001) $display("FAIL rr_wrap0: got %b want 0001", grant); else n_pass++;
    wait_done(100);
    req = 4'b0000;
    @(negedge clk50);
  endtask

  task automatic test_solid_zero;
    int n;
    pattern[3:2] = 2'b00;
    flashes[7:4] = 4'd0;
    req = 4'b0010;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0010) $display("FAIL solid_grant: got %b want 0010", grant); else n_pass++;
    @(negedge clk50);
    seg_len(1'b1, n);
    n_total++;
    if (n < 29 || n > 32) $display("FAIL solid_on: got %0d want 29..32", n); else n_pass++;
    n_total++;
    if (done !== 4'b0010 || led[0] !== 1'b0)
      $display("FAIL solid_done: got done=%b led0=%b want 0010/0", done, led[0]);
    else n_pass++;
    req = 4'b0000;
    @(negedge clk50);
  endtask

  task automatic test_abort;
    pattern[3:2] = 2'b01;
    flashes[7:4] = 4'd3;
    req = 4'b0010;
    @(negedge clk50);
    @(negedge clk50);
    n_total++;
    if (led !== 2'b11 || grant !== 4'b0010)
      $display("FAIL abort_on: got led=%b grant=%b want 11/0010", led, grant);
    else n_pass++;
    repeat (3) @(negedge clk50);
    req = 4'b0000;
    @(negedge clk50);
    n_total++;
    if (led !== 2'b00 || grant !== 4'b0000 || done !== 4'b0000)
      $display("FAIL abort_drop: got led=%b grant=%b done=%b want 00/0000/0000", led, grant, done);
    else n_pass++;
    req = 4'b0110;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0100) $display("FAIL abort_ptr: got %b want 0100", grant); else n_pass++;
    wait_done(100);
    req = 4'b0010;
    @(negedge clk50);
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0010) $display("FAIL abort_then1: got %b want 0010", grant); else n_pass++;
    wait_done(300);
    n_total++;
    if (done !== 4'b0010) $display("FAIL abort_done1: got %b want 0010", done); else n_pass++;
    req = 4'b0000;
    @(negedge clk50);
  endtask

  task automatic test_reset_mid;
    int n;
    pattern[1:0] = 2'b01;
    flashes[3:0] = 4'd1;
    req = 4'b0001;
    @(negedge clk50);
    @(negedge clk50);
    seg_len(1'b1, n);
    repeat (2) @(negedge clk50);
    n_total++;
    if (led !== 2'b10 || grant !== 4'b0001)
      $display("FAIL rstmid_off: got led=%b grant=%b want 10/0001", led, grant);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk50);
    n_total++;
    if ({grant, done, busy, led, blink} !== 12'h000)
      $display("FAIL rstmid_outputs: got %h want 000", {grant, done, busy, led, blink});
    else n_pass++;
    rst = 1'b0;
    req = 4'b1001;
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b0001) $display("FAIL rstmid_ptr: got %b want 0001", grant); else n_pass++;
    wait_done(100);
    n_total++;
    if (done !== 4'b0001) $display("FAIL rstmid_done0: got %b want 0001", done); else n_pass++;
    req = 4'b1000;
    @(negedge clk50);
    @(negedge clk50);
    n_total++;
    if (grant !== 4'b1000) $display("FAIL rstmid_next3: got %b want 1000", grant); else n_pass++;
    wait_done(100);
    req = 4'b0000;
    @(negedge clk50);
  endtask

  initial begin
    test_reset;
    test_slow;
    test_round_robin;
    test_solid_zero;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
